operand_load_unit: RTL and testbench
====================================

OPERAND_LOAD_UNIT -- requirements
Module: operand_load_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of operands, PC and register-file inputs.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  pipeline advance; low = stall, all state held.
REQ-005 SHALL have port loadControl  input  loadGroup::controlBus  registered operand-combo code from controller.
REQ-006 SHALL have port instrWord  input  32  instruction word aligned with loadControl.
REQ-007 SHALL have port nextPc  input  DATA_W  address of following instruction.
REQ-008 SHALL have port rfA / rfB  input  DATA_W each  register-file read ports A/B.
REQ-009 SHALL have port consume  input  1  execute stage takes current operands this cycle.
REQ-010 SHALL have ports operandA / operandB  output  DATA_W each  registered operands.
REQ-011 SHALL have port operandsValid  output  1  operandA/B hold an unconsumed pair.
REQ-012 SHALL have port loadStall  output  1  combinational; new load blocked by unconsumed pair.

Function
REQ-013 Decode per code (A source, B source): NEXTPC_IMM24 (nextPc, sext(instr[23:0])<<2); RFA_IMM19 (rfA, sext(instr[18:0])<<2); NEXTPC_IMM21B (nextPc, sext(instr[20:0])); NEXTPC_IMM21C (nextPc, sext({instr[25:21],instr[15:0]})); NULL_COMBO (0, 0); RFA_NULL (rfA, 0); RFA_IMM16A (rfA, sext(instr[15:0])); RFA_IMM16B (rfA, sext({instr[25:21],instr[10:0]})); RFA_IMM5 (rfA, zext(instr[4:0])); RFA_RFB (rfA, rfB).
REQ-014 Immediates SHALL sign/zero-extend to DATA_W before shift; shift discards overflow bits.
REQ-015 Load request = enable AND loadControl != NO_OP.
REQ-016 loadStall = load request AND operandsValid AND NOT consume.
REQ-017 Accepted load (request AND NOT loadStall) SHALL write operandA/B next edge, set operandsValid; latency 1 cycle.
REQ-018 consume without accepted load SHALL clear operandsValid next edge; operands retain value.
REQ-019 consume and accepted load same cycle SHALL load new pair, operandsValid stays 1 (back-to-back, no bubble).
REQ-020 Blocked load (loadStall=1) SHALL leave operands and operandsValid unchanged.
REQ-021 enable low SHALL hold operandA/B and operandsValid regardless of loadControl; consume still clears operandsValid.
REQ-022 consume while operandsValid=0 SHALL be ignored.
REQ-023 Unrecognised loadControl code SHALL behave as NO_OP.
REQ-024 Two-state control: EMPTY (operandsValid=0), FULL (=1); EMPTY->FULL on accepted load, FULL->EMPTY on consume without load, else hold.

Reset
REQ-025 reset SHALL override all inputs, including enable, on the same edge.
REQ-026 After reset: operandA=0, operandB=0, operandsValid=0, state EMPTY; loadStall=0.
REQ-027 reset mid-FULL SHALL discard pending pair; no consume needed.

Structure
REQ-028 Source-select enums, immediate field positions and shift amounts SHALL live in loadGroup beside controlBus.
REQ-029 Immediate extraction/extension SHALL be one combinational sub-module, operand_imm_gen (instrWord, loadControl -> immB).
REQ-030 Top SHALL hold only muxes, operand registers and valid state.

Verification
REQ-031 RFA_RFB, rfA=0x11, rfB=0x22, enable=1 -> next cycle operandA=0x11, operandB=0x22, operandsValid=1.
REQ-032 NEXTPC_IMM24, instr[23:0]=0xFFFFFF, nextPc=0x100 -> operandA=0x100, operandB=0xFFFFFFFC.
REQ-033 RFA_IMM16B, instr[25:21]=5'b10000, instr[10:0]=0 -> operandB=0xFFFF8000; RFA_IMM5 instr[4:0]=0x1F -> operandB=0x1F.
REQ-034 FULL, new RFA_IMM16A, consume=0 -> loadStall=1, operands unchanged; consume=1 next cycle -> new pair loaded, operandsValid=1.
REQ-035 FULL, enable=0, consume=1 -> operandsValid=0, operands held; NO_OP with enable=1 -> no change.
REQ-036 FULL, reset=1 with load request -> operandA/B=0, operandsValid=0 next edge.

Source files
------------

// File: rtl/operand_load_unit_pkg.sv
// ---------------------------------------------------------------------------
// loadGroup: shared definitions for the operand load unit.
//   controlBus    - operand-combo code issued by the controller
//   srcA_e/srcB_e - operand source selects
//   decode_t      - decoded (load, srcA, srcB) triple
//   IMM*_MSB/LSB  - immediate field positions inside instrWord
//   IMM*_SHIFT    - left-shift applied after extension
//   decode()      - maps a controlBus code to its source selects
// ---------------------------------------------------------------------------
package loadGroup;

   typedef enum logic [3:0] {
      NO_OP         = 4'd0,
      NEXTPC_IMM24  = 4'd1,
      RFA_IMM19     = 4'd2,
      NEXTPC_IMM21B = 4'd3,
      NEXTPC_IMM21C = 4'd4,
      NULL_COMBO    = 4'd5,
      RFA_NULL      = 4'd6,
      RFA_IMM16A    = 4'd7,
      RFA_IMM16B    = 4'd8,
      RFA_IMM5      = 4'd9,
      RFA_RFB       = 4'd10
   } controlBus;

   typedef enum logic [1:0] {
      SRC_A_ZERO,
      SRC_A_NEXTPC,
      SRC_A_RFA
   } srcA_e;

   typedef enum logic [1:0] {
      SRC_B_ZERO,
      SRC_B_IMM,
      SRC_B_RFB
   } srcB_e;

   typedef struct packed {
      logic  load;
      srcA_e srcA;
      srcB_e srcB;
   } decode_t;

   // Contiguous immediate fields (all start at bit 0)
   localparam int unsigned IMM24_MSB      = 23;
   localparam int unsigned IMM21_MSB      = 20;
   localparam int unsigned IMM19_MSB      = 18;
   localparam int unsigned IMM16_MSB      = 15;
   localparam int unsigned IMM5_MSB       = 4;

   // Split immediates: high part at [25:21], low part from bit 0
   localparam int unsigned SPLIT_HI_MSB   = 25;
   localparam int unsigned SPLIT_HI_LSB   = 21;
   localparam int unsigned SPLIT21_LO_MSB = 15;
   localparam int unsigned SPLIT16_LO_MSB = 10;

   localparam int unsigned IMM24_SHIFT    = 2;
   localparam int unsigned IMM19_SHIFT    = 2;

   // Codes outside the enumerated set fall to the default and act as NO_OP.
   function automatic decode_t decode(input controlBus code);
      decode_t d;
      d = '{load: 1'b0, srcA: SRC_A_ZERO, srcB: SRC_B_ZERO};
      case (code)
         NEXTPC_IMM24,
         NEXTPC_IMM21B,
         NEXTPC_IMM21C: d = '{load: 1'b1, srcA: SRC_A_NEXTPC, srcB: SRC_B_IMM};
         RFA_IMM19,
         RFA_IMM16A,
         RFA_IMM16B,
         RFA_IMM5:      d = '{load: 1'b1, srcA: SRC_A_RFA,    srcB: SRC_B_IMM};
         NULL_COMBO:    d = '{load: 1'b1, srcA: SRC_A_ZERO,   srcB: SRC_B_ZERO};
         RFA_NULL:      d = '{load: 1'b1, srcA: SRC_A_RFA,    srcB: SRC_B_ZERO};
         RFA_RFB:       d = '{load: 1'b1, srcA: SRC_A_RFA,    srcB: SRC_B_RFB};
         default:       d = '{load: 1'b0, srcA: SRC_A_ZERO,   srcB: SRC_B_ZERO};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/operand_load_unit_if.sv
// ---------------------------------------------------------------------------
// operand_load_unit_if: controller/execute-side bundle of the load unit.
//   master (driver side): enable, loadControl, instrWord, nextPc, rfA, rfB,
//                         consume out; operandA/B, operandsValid, loadStall in
//   slave  (the unit)   : the reverse
// ---------------------------------------------------------------------------
interface operand_load_unit_if #(
   parameter int unsigned DATA_W = 32
) ();
   import loadGroup::*;

   logic              enable;
   controlBus         loadControl;
   logic [31:0]       instrWord;
   logic [DATA_W-1:0] nextPc;
   logic [DATA_W-1:0] rfA;
   logic [DATA_W-1:0] rfB;
   logic              consume;
   logic [DATA_W-1:0] operandA;
   logic [DATA_W-1:0] operandB;
   logic              operandsValid;
   logic              loadStall;

   modport master (
      output enable, loadControl, instrWord, nextPc, rfA, rfB, consume,
      input  operandA, operandB, operandsValid, loadStall
   );

   modport slave (
      input  enable, loadControl, instrWord, nextPc, rfA, rfB, consume,
      output operandA, operandB, operandsValid, loadStall
   );

endinterface

// File: rtl/operand_load_unit_imm_gen.sv
// ---------------------------------------------------------------------------
// operand_imm_gen: combinational immediate extraction for operand B.
//   instrWord   in  - instruction word
//   loadControl in  - operand-combo code
//   immB        out - immediate extended to DATA_W, then shifted
// Extension happens at full width before the shift, so shifted-out bits
// are simply discarded.
// ---------------------------------------------------------------------------
module operand_imm_gen
   import loadGroup::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [31:0]       instrWord,
   input  controlBus         loadControl,
   output logic [DATA_W-1:0] immB
);

   // Bits [31:26] never carry immediate data
   logic w_unused_opcode;
   assign w_unused_opcode = ^instrWord[31:SPLIT_HI_MSB+1];

   always_comb begin
      immB = '0;
      case (loadControl)
         NEXTPC_IMM24:  immB = DATA_W'($signed(instrWord[IMM24_MSB:0])) << IMM24_SHIFT;
         RFA_IMM19:     immB = DATA_W'($signed(instrWord[IMM19_MSB:0])) << IMM19_SHIFT;
         NEXTPC_IMM21B: immB = DATA_W'($signed(instrWord[IMM21_MSB:0]));
         NEXTPC_IMM21C: immB = DATA_W'($signed({instrWord[SPLIT_HI_MSB:SPLIT_HI_LSB],
                                                instrWord[SPLIT21_LO_MSB:0]}));
         RFA_IMM16A:    immB = DATA_W'($signed(instrWord[IMM16_MSB:0]));
         RFA_IMM16B:    immB = DATA_W'($signed({instrWord[SPLIT_HI_MSB:SPLIT_HI_LSB],
                                                instrWord[SPLIT16_LO_MSB:0]}));
         RFA_IMM5:      immB = DATA_W'(instrWord[IMM5_MSB:0]);
         default:       immB = '0;
      endcase
   end

endmodule

// File: rtl/operand_load_unit.sv
// ---------------------------------------------------------------------------
// operand_load_unit: selects and registers the A/B operand pair for execute.
//   clk   in - single clock, rising edge
//   reset in - synchronous, active-high; overrides every other input
//   bus       - operand_load_unit_if.slave (controller inputs, operands,
//               operandsValid, combinational loadStall)
// A one-entry holding stage: EMPTY accepts any load; FULL accepts a load
// only in the cycle execute consumes the current pair (no bubble).
// ---------------------------------------------------------------------------
module operand_load_unit
   import loadGroup::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   operand_load_unit_if.slave  bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e            r_state;
   state_e            w_state_nxt;
   logic [DATA_W-1:0] r_opA;
   logic [DATA_W-1:0] r_opB;

   decode_t           w_dec;
   logic [DATA_W-1:0] w_immB;
   logic [DATA_W-1:0] w_selA;
   logic [DATA_W-1:0] w_selB;
   logic              w_req;
   logic              w_stall;
   logic              w_accept;

   operand_imm_gen #(
      .DATA_W (DATA_W)
   ) u_imm_gen (
      .instrWord   (bus.instrWord),
      .loadControl (bus.loadControl),
      .immB        (w_immB)
   );

   assign w_dec    = decode(bus.loadControl);
   assign w_req    = bus.enable & w_dec.load;
   assign w_stall  = w_req & (r_state == FULL) & ~bus.consume;
   assign w_accept = w_req & ~w_stall;

   always_comb begin
      w_selA = '0;
      case (w_dec.srcA)
         SRC_A_NEXTPC: w_selA = bus.nextPc;
         SRC_A_RFA:    w_selA = bus.rfA;
         default:      w_selA = '0;
      endcase
   end

   always_comb begin
      w_selB = '0;
      case (w_dec.srcB)
         SRC_B_IMM: w_selB = w_immB;
         SRC_B_RFB: w_selB = bus.rfB;
         default:   w_selB = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // consume acts even when enable is low; it is ignored while EMPTY
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY: if (w_accept) w_state_nxt = FULL;
         FULL: begin
            if (w_accept)         w_state_nxt = FULL;
            else if (bus.consume) w_state_nxt = EMPTY;
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_opA <= '0;
         r_opB <= '0;
      end else if (w_accept) begin
         r_opA <= w_selA;
         r_opB <= w_selB;
      end
   end

   assign bus.operandA      = r_opA;
   assign bus.operandB      = r_opB;
   assign bus.operandsValid = (r_state == FULL);
   assign bus.loadStall     = w_stall;

endmodule

// File: tb/tb_operand_load_unit.sv
// ---------------------------------------------------------------------------
// tb_operand_load_unit: directed + random stimulus, reference model of the
// operand pair, scoreboard queue drained by an independent monitor.
// ---------------------------------------------------------------------------
module tb_operand_load_unit;
   import loadGroup::*;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        v;
      logic        stall;
   } exp_t;

   logic clk;
   logic reset;

   operand_load_unit_if #(.DATA_W(32)) bif ();

   operand_load_unit #(
      .DATA_W (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_a = '0;
   logic [31:0] m_b = '0;
   logic        m_v = 1'b0;

   // Sign-extend an n-bit field held in v
   function automatic longint sx(input longint v, input int n);
      if (v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
      return v;
   endfunction

   function automatic void ref_pair(input logic [3:0] code, input logic [31:0] instr,
                                    input logic [31:0] pc, input logic [31:0] ra,
                                    input logic [31:0] rb, output logic ok,
                                    output logic [31:0] ea, output logic [31:0] eb);
      longint f;
      ok = 1'b1; ea = 32'd0; eb = 32'd0;
      case (code)
         4'd1:  begin ea = pc; eb = 32'(sx(longint'(instr[23:0]), 24) * 4); end
         4'd2:  begin ea = ra; eb = 32'(sx(longint'(instr[18:0]), 19) * 4); end
         4'd3:  begin ea = pc; eb = 32'(sx(longint'(instr[20:0]), 21)); end
         4'd4:  begin
                   f  = longint'(instr[25:21]) * 65536 + longint'(instr[15:0]);
                   ea = pc; eb = 32'(sx(f, 21));
                end
         4'd5:  begin ea = 32'd0; eb = 32'd0; end
         4'd6:  begin ea = ra; eb = 32'd0; end
         4'd7:  begin ea = ra; eb = 32'(sx(longint'(instr[15:0]), 16)); end
         4'd8:  begin
                   f  = longint'(instr[25:21]) * 2048 + longint'(instr[10:0]);
                   ea = ra; eb = 32'(sx(f, 16));
                end
         4'd9:  begin ea = ra; eb = 32'(instr[4:0]); end
         4'd10: begin ea = ra; eb = rb; end
         default: ok = 1'b0;
      endcase
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   // One cycle of stimulus: drive, record expectation, advance the model
   task automatic cyc(input logic rst, input logic en, input logic [3:0] code,
                      input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] ra, input logic [31:0] rb, input logic cons);
      exp_t        r;
      logic        ok, req, stall;
      logic [31:0] na, nb;
      @(posedge clk);
      #1;
      reset           = rst;
      bif.enable      = en;
      bif.loadControl = controlBus'(code);
      bif.instrWord   = instr;
      bif.nextPc      = pc;
      bif.rfA         = ra;
      bif.rfB         = rb;
      bif.consume     = cons;
      ref_pair(code, instr, pc, ra, rb, ok, na, nb);
      req   = en && ok;
      stall = req && m_v && !cons;
      r.a = m_a; r.b = m_b; r.v = m_v; r.stall = stall;
      q.push_back(r);
      if (rst) begin
         m_a = '0; m_b = '0; m_v = 1'b0;
      end else if (req && !stall) begin
         m_a = na; m_b = nb; m_v = 1'b1;
      end else if (cons) begin
         m_v = 1'b0;
      end
   endtask

   // Monitor: registered outputs reflect the previous edge, loadStall the
   // inputs driven this cycle
   initial begin
      exp_t r;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            r = q.pop_front();
            chk("operandA",      bif.operandA,               r.a);
            chk("operandB",      bif.operandB,               r.b);
            chk("operandsValid", 32'(bif.operandsValid),     32'(r.v));
            chk("loadStall",     32'(bif.loadStall),         32'(r.stall));
         end
      end
   end

   initial begin
      logic [3:0] code;
      reset           = 1'b1;
      bif.enable      = 1'b0;
      bif.loadControl = NO_OP;
      bif.instrWord   = '0;
      bif.nextPc      = '0;
      bif.rfA         = '0;
      bif.rfB         = '0;
      bif.consume     = 1'b0;
      repeat (2) @(posedge clk);

      // reset state, including a load request under reset
      cyc(1, 1, 4'd10, 32'h0, 32'h0, 32'h5, 32'h6, 0);
      // RFA_RFB basic load
      cyc(0, 1, 4'd10, 32'h0, 32'h0, 32'h11, 32'h22, 0);
      // back-to-back: NEXTPC_IMM24 with consume, negative imm
      cyc(0, 1, 4'd1, 32'h00FF_FFFF, 32'h100, 32'h0, 32'h0, 1);
      // blocked RFA_IMM16A, then accepted with consume
      cyc(0, 1, 4'd7, 32'h0000_8001, 32'h0, 32'h33, 32'h0, 0);
      cyc(0, 1, 4'd7, 32'h0000_8001, 32'h0, 32'h33, 32'h0, 1);
      // split IMM16B with high sign bit, then IMM5 max
      cyc(0, 1, 4'd8, 32'h0200_0000, 32'h0, 32'h44, 32'h0, 1);
      cyc(0, 1, 4'd9, 32'hFFFF_FFFF, 32'h0, 32'h55, 32'h0, 1);
      // enable low: consume clears valid, load ignored
      cyc(0, 0, 4'd10, 32'h0, 32'h0, 32'h66, 32'h77, 1);
      // NO_OP and unrecognised code: no change
      cyc(0, 1, 4'd0, 32'h0, 32'h0, 32'h88, 32'h99, 0);
      cyc(0, 1, 4'd15, 32'h0, 32'h0, 32'h88, 32'h99, 0);
      // consume while empty is ignored
      cyc(0, 0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1);
      // fill, then reset with a pending pair and a load request
      cyc(0, 1, 4'd6, 32'h0, 32'h0, 32'hAB, 32'h0, 0);
      cyc(1, 1, 4'd10, 32'h0, 32'h0, 32'h1, 32'h2, 0);
      // remaining immediate forms
      cyc(0, 1, 4'd2, 32'h0004_0000, 32'h0, 32'h12, 32'h0, 0);
      cyc(0, 1, 4'd3, 32'h0010_0000, 32'h200, 32'h0, 32'h0, 1);
      cyc(0, 1, 4'd4, 32'h0200_0000, 32'h300, 32'h0, 32'h0, 1);
      cyc(0, 1, 4'd5, 32'hFFFF_FFFF, 32'h400, 32'hF, 32'hF, 1);

      for (int i = 0; i < 600; i++) begin
         code = 4'($urandom_range(0, 15));
         cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), code,
             $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 1) == 1);
      end
      cyc(0, 0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0);

      for (int i = 0; i < 4 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
